// File: rtl/reg_share_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// reg_share_pkg
// Purpose : shared types and constants for the register-sharing arbiter.
//           Holds the controller state enum, default sizing constants and
//           the helper that turns a requester count into an index width.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package reg_share_pkg;

    // Default sizing: requesters, data width, write-counter width.
    localparam int DEF_N  = 4;
    localparam int DEF_W  = 8;
    localparam int DEF_CW = 8;

    // Number of bits needed to name one requester.
    // Kept at least 1 so the owner/pointer fields never collapse to zero width.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_IW = idxWidth(DEF_N);

    // Controller states: pick a winner, load the register, acknowledge, then
    // wait for the winner to let go before arbitrating again.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        ACK     = 2'd2,
        RELEASE = 2'd3
    } state_t;

endpackage

// File: rtl/reg_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// reg_share_arbiter_if
// Purpose : bundles the requester-side and status signals of the arbiter.
// Signals : req      - per-requester level request
//           wdata    - flattened data, requester i at [i*W +: W]
//           gnt      - one-hot grant, held from selection until release
//           ack      - one-hot one-cycle pulse once the word is loaded
//           q        - shared register contents
//           owner    - index of the last/current winner
//           busy     - arbiter is not idle
//           wr_count - completed writes, wrapping
// Modports: master drives requests/data, slave is the arbiter.
// ---------------------------------------------------------------------------
interface reg_share_arbiter_if
    import reg_share_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int W  = DEF_W,
    parameter int CW = DEF_CW
) ();

    localparam int IW = idxWidth(N);

    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic [W-1:0]   q;
    logic [IW-1:0]  owner;
    logic           busy;
    logic [CW-1:0]  wr_count;

    modport master (
        output req, wdata,
        input  gnt, ack, q, owner, busy, wr_count
    );

    modport slave (
        input  req, wdata,
        output gnt, ack, q, owner, busy, wr_count
    );

endinterface

// File: rtl/reg_share_arbiter_cells.sv
// ---------------------------------------------------------------------------
// rr_pick / en_dff
// Purpose : leaf cells used by reg_share_arbiter.
//   rr_pick - combinational round-robin selector.
//             Ports: req_i (N requests), ptr_i (search start index),
//                    winner_o (selected index), valid_o (any request set).
//   en_dff  - single-bit enabled D flip-flop with async active-low reset.
//             Ports: clk, reset (active-low), en_i, d_i, q_o.
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] winner_o,
    output logic          valid_o
);

    // Walk the requests starting at the pointer and wrapping around; the
    // first set bit met wins, so the pointer position has top priority.
    always_comb begin
        int  idx;
        logic found;
        idx      = 0;
        found    = 1'b0;
        winner_o = '0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_i) + i) % N;
            if (!found && req_i[idx]) begin
                found    = 1'b1;
                winner_o = IW'(idx);
            end
        end
        valid_o = found;
    end

endmodule

module en_dff (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic d_i,
    output logic q_o
);

    logic q_q;

    // Storage bit: clears on reset, otherwise only captures when enabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q <= 1'b0;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/reg_share_arbiter.sv
// ---------------------------------------------------------------------------
// reg_share_arbiter
// Purpose : shares one enable-gated W-bit register between N requesters.
//           A round-robin pick chooses one requester, its word is loaded in
//           a single WRITE cycle, it gets a one-cycle ack, and the grant is
//           held until that requester drops its request.
// Ports   : clk    - system clock, rising edge
//           reset  - asynchronous, active-low
//           bus    - reg_share_arbiter_if.slave (req/wdata in; gnt, ack, q,
//                    owner, busy, wr_count out)
// ---------------------------------------------------------------------------
module reg_share_arbiter
    import reg_share_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int W  = DEF_W,
    parameter int CW = DEF_CW
) (
    input  logic                  clk,
    input  logic                  reset,
    reg_share_arbiter_if.slave    bus
);

    localparam int IW = idxWidth(N);

    state_t        state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] ptr_q,   ptr_d;
    logic [N-1:0]  gnt_q,   gnt_d;
    logic [CW-1:0] wrCount_q, wrCount_d;

    logic [IW-1:0] pickIdx;
    logic          pickValid;
    logic [N-1:0]  ownerMask;
    logic          en;
    logic [W-1:0]  selWord;
    logic [W-1:0]  qWord;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req_i    (bus.req),
        .ptr_i    (ptr_q),
        .winner_o (pickIdx),
        .valid_o  (pickValid)
    );

    assign ownerMask = {{(N-1){1'b0}}, 1'b1} << owner_q;

    // State and bookkeeping registers. A reset at any point abandons the
    // transaction in flight, so the pointer also returns to requester 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            gnt_q     <= '0;
            wrCount_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            wrCount_q <= wrCount_d;
        end
    end

    // Next-state logic. Everything holds by default; each state only
    // touches what it owns. The pointer moves past the winner in ACK so the
    // winner becomes the lowest priority for the next arbitration.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        wrCount_d = wrCount_q;
        case (state_q)
            IDLE: begin
                if (pickValid) begin
                    owner_d = pickIdx;
                    gnt_d   = {{(N-1){1'b0}}, 1'b1} << pickIdx;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                state_d = ACK;
            end
            ACK: begin
                wrCount_d = wrCount_q + 1'b1;
                ptr_d     = (owner_q == IW'(N-1)) ? '0 : owner_q + 1'b1;
                state_d   = RELEASE;
            end
            RELEASE: begin
                if (!bus.req[owner_q]) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // The register enable is only ever high in WRITE, so a request held in
    // RELEASE cannot cause a second load.
    assign en      = (state_q == WRITE);
    assign selWord = bus.wdata[int'(owner_q)*W +: W];

    // The shared data register, built from enabled flip-flop cells.
    for (genvar b = 0; b < W; b++) begin : g_reg
        en_dff u_bit (
            .clk   (clk),
            .reset (reset),
            .en_i  (en),
            .d_i   (selWord[b]),
            .q_o   (qWord[b])
        );
    end

    assign bus.q        = qWord;
    assign bus.gnt      = gnt_q;
    assign bus.ack      = (state_q == ACK) ? ownerMask : '0;
    assign bus.owner    = owner_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.wr_count = wrCount_q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_share_arbiter
// Purpose : self-checking bench for reg_share_arbiter. A reference model
//           predicts each transaction's winner, data and count; expected
//           acks are queued and checked by an independent monitor.
// ---------------------------------------------------------------------------
module tb_reg_share_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int CW = 8;
    localparam int LW = N * W;

    typedef struct {
        int            w;
        logic [W-1:0]  data;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk;
    logic reset;

    reg_share_arbiter_if #(.N(N), .W(W), .CW(CW)) bus ();

    reg_share_arbiter #(.N(N), .W(W), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   checks;
    int   errors;
    exp_t expQ[$];
    int   modelPtr;
    int   modelCount;
    logic [N-1:0] lastAck;

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference arbitration: first requester at or after the pointer, wrapping.
    function automatic int modelPick(input logic [N-1:0] m);
        for (int k = 0; k < N; k++) begin
            if (m[(modelPtr + k) % N]) return (modelPtr + k) % N;
        end
        return 0;
    endfunction

    // Monitor: every ack the DUT shows must match the oldest queued prediction.
    always @(negedge clk) begin
        if (reset && bus.ack != '0) begin
            if (lastAck != '0) checkOutput("ackPulseWidth", 32'(lastAck & bus.ack), 0);
            if (expQ.size() == 0) begin
                checkOutput("unexpectedAck", 32'(bus.ack), 0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("ackOneHot", 32'(bus.ack), 32'(1) << e.w);
                checkOutput("ackUnderGnt", 32'(bus.gnt), 32'(bus.ack));
                checkOutput("ackData", 32'(bus.q), 32'(e.data));
                checkOutput("ackOwner", 32'(bus.owner), 32'(e.w));
                checkOutput("ackCount", 32'(bus.wr_count), 32'(e.cnt));
            end
        end
        lastAck = reset ? bus.ack : '0;
    end

    // One full transaction starting at a negedge with the DUT idle. The winner
    // keeps its request for 'hold' cycles after ack, then req becomes 'remain'.
    task automatic applyStimulus(input logic [N-1:0] mask, input logic [LW-1:0] data,
                                 input int hold, input logic [N-1:0] remain);
        int   w;
        int   cyc;
        exp_t e;
        w      = modelPick(mask);
        e.w    = w;
        e.data = data[w*W +: W];
        e.cnt  = CW'(modelCount);
        expQ.push_back(e);
        modelCount = (modelCount + 1) % (1 << CW);
        modelPtr   = (w + 1) % N;
        bus.req   = mask;
        bus.wdata = data;
        @(posedge clk); #1;
        checkOutput("grant", 32'(bus.gnt), 32'(1) << w);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (bus.ack == '0 && cyc < 8);
        if (bus.ack == '0) checkOutput("ackTimeout", 32'(bus.ack), 32'(1) << w);
        for (int h = 0; h < hold; h++) begin
            bus.wdata = LW'($urandom);
            @(negedge clk);
            checkOutput("holdGrant", 32'(bus.gnt), 32'(1) << w);
            checkOutput("holdNoAck", 32'(bus.ack), 0);
            checkOutput("holdQ", 32'(bus.q), 32'(e.data));
        end
        bus.req = remain;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (bus.busy && cyc < 4);
        checkOutput("releaseIdle", 32'(bus.busy), 0);
        checkOutput("releaseGnt", 32'(bus.gnt), 0);
        checkOutput("ownerAfter", 32'(bus.owner), 32'(w));
        checkOutput("countAfter", 32'(bus.wr_count), 32'(modelCount));
        @(negedge clk);
    endtask

    // Main sequence: reset, directed cases, then random traffic up to wrap.
    initial begin
        logic [LW-1:0] d;
        logic [N-1:0]  m;
        checks     = 0;
        errors     = 0;
        modelPtr   = 0;
        modelCount = 0;
        lastAck    = '0;
        reset      = 1'b0;
        bus.req    = 4'b1111;
        bus.wdata  = LW'(32'h44332211);

        repeat (3) @(negedge clk);
        checkOutput("rstGnt", 32'(bus.gnt), 0);
        checkOutput("rstAck", 32'(bus.ack), 0);
        checkOutput("rstQ", 32'(bus.q), 0);
        checkOutput("rstBusy", 32'(bus.busy), 0);
        checkOutput("rstCount", 32'(bus.wr_count), 0);
        checkOutput("rstOwner", 32'(bus.owner), 0);
        reset = 1'b1;
        applyStimulus(4'b1111, LW'(32'h44332211), 0, '0);

        $display("[TB] single request");
        applyStimulus(4'b0100, LW'(32'h00A50000), 1, '0);

        $display("[TB] fairness");
        for (int t = 0; t < 5; t++) applyStimulus(4'b1111, LW'($urandom), 1, '0);

        $display("[TB] held request");
        applyStimulus(4'b1010, LW'($urandom), 10, 4'b1000);
        applyStimulus(4'b1000, LW'($urandom), 0, '0);

        $display("[TB] mid-operation reset");
        applyStimulus(4'b0010, LW'($urandom), 0, '0);
        bus.req   = 4'b0110;
        bus.wdata = LW'(32'h003C5A00);
        @(posedge clk); #1;
        checkOutput("preResetGrant", 32'(bus.gnt), 32'h4);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("midRstQ", 32'(bus.q), 0);
        checkOutput("midRstGnt", 32'(bus.gnt), 0);
        checkOutput("midRstBusy", 32'(bus.busy), 0);
        checkOutput("midRstCount", 32'(bus.wr_count), 0);
        repeat (2) @(negedge clk);
        checkOutput("midRstQHeld", 32'(bus.q), 0);
        modelPtr   = 0;
        modelCount = 0;
        reset      = 1'b1;
        applyStimulus(4'b0110, LW'(32'h003C5A00), 1, '0);

        $display("[TB] random traffic to counter wrap");
        while (modelCount != (1 << CW) - 1) begin
            m = N'($urandom_range(1, (1 << N) - 1));
            d = LW'($urandom);
            applyStimulus(m, d, int'($urandom_range(0, 2)), '0);
        end
        checkOutput("wrapPreload", 32'(bus.wr_count), 32'hFF);
        applyStimulus(N'($urandom_range(1, (1 << N) - 1)), LW'($urandom), 1, '0);
        checkOutput("wrapZero", 32'(bus.wr_count), 0);

        repeat (3) @(negedge clk);
        checkOutput("queueDrained", 32'(expQ.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
